fetch_unit: RTL

//  Consumer end of the program-counter interface: reads the current PC, fetches the word
//  at that address from instruction memory over a req/ack handshake and queues it for

---
 rtl/fetch_unit.sv | 115 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the PC, fetches over a req/ack port and queues words for decode.
// Build option FETCH_JMP_FOLD_EN: when defined, jump words are consumed here and never enqueued.
module fetch_unit #(
   parameter int          ADDR_W     = 8,
   parameter int          DATA_W     = 16,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [3:0]  JMP_OPCODE = 4'hA
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic [ADDR_W-1:0] pcIn,
   output logic              hold,
   output logic              jump,
   output logic [ADDR_W-1:0] jumpLine,
   output logic              memReq,
   output logic [ADDR_W-1:0] memAddr,
   input  logic              memAck,
   input  logic [DATA_W-1:0] memData,
   output logic              instrValid,
   input  logic              instrReady,
   output logic [DATA_W-1:0] instrData,
   output logic [ADDR_W-1:0] instrAddr
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   localparam logic [0:0] S_FETCH = 1'b0;
   localparam logic [0:0] S_STALL = 1'b1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t            fifo_q [FIFO_DEPTH];
   logic [0:0]        state_q, state_d;
   logic              run_q;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic full, empty, accept, is_jmp, push, pop;

   assign full    = (cnt_q == CNT_W'(FIFO_DEPTH));
   assign empty   = (cnt_q == '0);

   // run_q keeps memReq low on the first cycle after reset release
   assign memReq  = run_q & (state_q == S_FETCH);
   assign memAddr = pcIn;

   // a full queue refuses the word even if decode pops in the same cycle
   assign accept  = memReq & memAck & ~full;
   assign is_jmp  = (memData[DATA_W-1 -: 4] == JMP_OPCODE);

   assign hold     = ~accept;
   assign jump     = accept & is_jmp;
   assign jumpLine = memData[ADDR_W-1:0];

`ifdef FETCH_JMP_FOLD_EN
   assign push = accept & ~is_jmp;
`else
   assign push = accept;
`endif

   assign pop        = instrReady & ~empty;
   assign instrValid = ~empty;
   assign instrData  = fifo_q[rd_ptr_q].data;
   assign instrAddr  = fifo_q[rd_ptr_q].addr;

   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      cnt_d    = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // stalling drops memReq, abandoning any un-acked request; it is re-issued at the same PC
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: if (run_q && full && !pop) state_d = S_STALL;
         S_STALL: if (pop)                   state_d = S_FETCH;
         default:                            state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q  <= S_FETCH;
         run_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         run_q    <= 1'b1;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr_q].addr <= pcIn;
         fifo_q[wr_ptr_q].data <= memData;
      end
   end

endmodule
